mag_power_ctrl: RTL and testbench
=================================

// Module: mag_power_ctrl
// PURPOSE
//   Clocked successor to the microwave control logic. Drives the magnetron enable from the
//   active-low start/stop/clear buttons, the door interlock and the cook-timer done flag.
//   Adds a 4-state FSM (idle/cook/pause/done) and parametrised power levels realised as a
//   duty cycle over a fixed window. Sits between the button/door front end and the magnetron driver.
// PARAMETERS
//   PWR_LEVELS   4   number of selectable power levels (>=2)
//   DUTY_PERIOD  16  cycles per duty window (>= PWR_LEVELS)
//   DEB_CYCLES   4   stable cycles required by the debouncer (used only with MAG_DEBOUNCE_EN)
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   rst          in   1      synchronous, active-high reset
//   startn       in   1      start button, active low
//   stopn        in   1      stop button, active low
//   clearn       in   1      clear button, active low
//   door_closed  in   1      1 = door closed (interlock)
//   timer_done   in   1      1 = cook timer expired
//   power_level  in   LVL_W  requested level 0..PWR_LEVELS-1; LVL_W = $clog2(PWR_LEVELS)
//   mag          out  1      magnetron enable
//   cooking      out  1      1 while state == COOK
//   paused       out  1      1 while state == PAUSE
//   done         out  1      1 while state == DONE
// BEHAVIOUR
//   - Reset: state=IDLE, duty_cnt=0, lvl_q=0, button history regs=1; mag/cooking/paused/done=0.
//   - Button events are falling edges: evt = prev & ~cur on the sampled signal; a held-low
//     button produces one event only. stopn and clearn are also edge events.
//   - States: IDLE=2'd0, COOK=2'd1, PAUSE=2'd2, DONE=2'd3.
//   - IDLE:  start_evt & door_closed & ~timer_done -> COOK; lvl_q <= power_level; duty_cnt <= 0.
//   - COOK:  priority clear_evt -> IDLE; else ~door_closed -> PAUSE; else stop_evt -> PAUSE;
//            else timer_done -> DONE. duty_cnt increments mod DUTY_PERIOD every COOK cycle.
//   - PAUSE: clear_evt -> IDLE; start_evt & door_closed -> COOK (duty_cnt held, resumes).
//   - DONE:  clear_evt or ~door_closed -> IDLE; start_evt ignored.
//   - on_cycles = ((lvl_q+1)*DUTY_PERIOD)/PWR_LEVELS, integer floor, always >=1.
//   - mag = (state==COOK) & door_closed & (duty_cnt < on_cycles); combinational decode of
//     registers plus door_closed, so door opening kills mag in the same cycle (safety path).
//   - Latency: start event at edge N -> cooking=1 and mag=1 after edge N.
//   - power_level changes while in COOK/PAUSE are ignored; sampled only on IDLE->COOK.
//   - Out-of-range power_level (>= PWR_LEVELS) is clamped to PWR_LEVELS-1.
//   - rst asserted mid-cook: next edge returns to reset values regardless of inputs.
// CONFIGURATION
//   MAG_DEBOUNCE_EN defined: startn/stopn/clearn each pass through button_debounce; output
//     changes only after DEB_CYCLES consecutive equal samples; adds DEB_CYCLES+1 cycles to event latency.
//   Undefined: buttons feed the edge detector directly (one register stage); DEB_CYCLES unused.
//   door_closed and timer_done are never debounced in either build.
// STRUCTURE
//   - Package mag_ctrl_pkg: state encodings (ST_IDLE..ST_DONE), state width constant,
//     on_cycles function.
//   - Sub-module button_debounce (param DEB_CYCLES, ports clk, rst, din, dout; reset dout=1),
//     instantiated x3 only under MAG_DEBOUNCE_EN.
//   - Top holds FSM, edge detectors, duty counter, level register.
// TESTING (PWR_LEVELS=4, DUTY_PERIOD=16, debounce off unless noted)
//   1 rst=1 for 2 cycles with random inputs -> mag=0, cooking=0, paused=0, done=0, state IDLE.
//   2 door_closed=1, power_level=1, startn 1->0 -> cooking=1 next edge; mag high 8 of every 16 cycles.
//   3 level 3 cooking, door_closed 1->0 -> mag=0 same cycle, paused=1 next edge; close door,
//     startn pulse -> cooking resumes with duty_cnt continuing from held value.
//   4 COOK, timer_done=1 -> done=1, mag=0; startn pulse -> stays DONE; clearn pulse -> IDLE.
//   5 COOK, clearn and stopn fall same cycle with timer_done=1 -> IDLE (clear wins).
//   6 door open, startn held 0, then door closes -> remains IDLE (no new edge);
//     with MAG_DEBOUNCE_EN, 2-cycle startn glitch -> no start.

Source files
------------

// File: rtl/mag_ctrl_pkg.sv
// mag_ctrl_pkg
//   Shared definitions for the magnetron power controller.
//   - mag_state_t : FSM state encoding (IDLE/COOK/PAUSE/DONE)
//   - STATE_W     : width of the state register
//   - on_cycles() : number of "on" cycles in a duty window for a given level
package mag_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_COOK  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } mag_state_t;

    // Level 0 would round down to zero on coarse windows; a selected level
    // must always heat, so the result is floored at one cycle.
    function automatic int on_cycles(input int lvl, input int levels, input int period);
        int n;
        n = ((lvl + 1) * period) / levels;
        if (n < 1) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   Debounces one active-low push button. The output follows the input only
//   after DEB_CYCLES consecutive samples that disagree with the current
//   output; shorter glitches are discarded.
//   Only compiled into the build when MAG_DEBOUNCE_EN is defined.
// Parameters
//   DEB_CYCLES  consecutive equal samples required before dout changes
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (dout resets to 1 = released)
//   din   in   raw button level
//   dout  out  debounced button level
`ifdef MAG_DEBOUNCE_EN
module button_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

    logic          din_q;
    logic [CW-1:0] cnt;

    // The input is registered once before comparison so the counter never
    // sees an asynchronous level directly; the counter restarts whenever the
    // sample agrees with the current output again.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b1;
            dout  <= 1'b1;
            cnt   <= '0;
        end else begin
            din_q <= din;
            if (din_q == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                dout <= din_q;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/mag_power_ctrl.sv
// mag_power_ctrl
//   Microwave magnetron power controller. Turns the active-low start/stop/
//   clear buttons, the door interlock and the cook-timer flag into a
//   magnetron enable, with a selectable power level realised as a duty cycle
//   over a fixed window of DUTY_PERIOD cycles.
//   Optional feature macro: MAG_DEBOUNCE_EN (debounce the three buttons).
// Parameters
//   PWR_LEVELS   number of power levels (>= 2)
//   DUTY_PERIOD  cycles per duty window (>= PWR_LEVELS)
//   DEB_CYCLES   debounce length, only meaningful with MAG_DEBOUNCE_EN
// Ports
//   clk          in   single rising-edge clock
//   rst          in   synchronous active-high reset
//   startn       in   start button, active low
//   stopn        in   stop button, active low
//   clearn       in   clear button, active low
//   door_closed  in   1 = door closed
//   timer_done   in   1 = cook timer expired
//   power_level  in   requested level, clamped to PWR_LEVELS-1
//   mag          out  magnetron enable
//   cooking      out  state is COOK
//   paused       out  state is PAUSE
//   done         out  state is DONE
module mag_power_ctrl
    import mag_ctrl_pkg::*;
#(
    parameter int PWR_LEVELS  = 4,
    parameter int DUTY_PERIOD = 16,
    parameter int DEB_CYCLES  = 4,
    parameter int LVL_W       = (PWR_LEVELS > 1) ? $clog2(PWR_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startn,
    input  logic             stopn,
    input  logic             clearn,
    input  logic             door_closed,
    input  logic             timer_done,
    input  logic [LVL_W-1:0] power_level,
    output logic             mag,
    output logic             cooking,
    output logic             paused,
    output logic             done
);

    localparam int CNT_W = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;

    if (PWR_LEVELS < 2 || DUTY_PERIOD < PWR_LEVELS || DEB_CYCLES < 1) begin : g_bad_params
        $error("mag_power_ctrl: unsupported parameter combination");
    end

    mag_state_t       state, next_state;
    logic [CNT_W-1:0] duty_cnt;
    logic [LVL_W-1:0] lvl_q, lvl_in;
    logic             start_cur, stop_cur, clear_cur;
    logic             start_prev, stop_prev, clear_prev;
    logic             start_evt, stop_evt, clear_evt;
    logic             load_lvl;
    int               on_cyc;

`ifdef MAG_DEBOUNCE_EN
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk(clk), .rst(rst), .din(startn), .dout(start_cur)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
        .clk(clk), .rst(rst), .din(stopn), .dout(stop_cur)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk(clk), .rst(rst), .din(clearn), .dout(clear_cur)
    );
`else
    assign start_cur = startn;
    assign stop_cur  = stopn;
    assign clear_cur = clearn;
`endif

    // Falling edge of a button level: a held-low button fires only once.
    assign start_evt = start_prev & ~start_cur;
    assign stop_evt  = stop_prev  & ~stop_cur;
    assign clear_evt = clear_prev & ~clear_cur;

    always_comb begin
        lvl_in = power_level;
        if (int'(power_level) > PWR_LEVELS - 1) begin
            lvl_in = LVL_W'(PWR_LEVELS - 1);
        end
    end

    assign on_cyc = on_cycles(int'(lvl_q), PWR_LEVELS, DUTY_PERIOD);

    // The duty counter only advances in COOK, so a pause freezes the window
    // position and resuming continues where heating left off. The level is
    // latched only on a fresh start, never on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            duty_cnt   <= '0;
            lvl_q      <= '0;
            start_prev <= 1'b1;
            stop_prev  <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            state      <= next_state;
            start_prev <= start_cur;
            stop_prev  <= stop_cur;
            clear_prev <= clear_cur;
            if (load_lvl) begin
                lvl_q    <= lvl_in;
                duty_cnt <= '0;
            end else if (state == ST_COOK) begin
                duty_cnt <= (duty_cnt == CNT_W'(DUTY_PERIOD - 1)) ? '0 : duty_cnt + CNT_W'(1);
            end
        end
    end

    // mag uses door_closed directly rather than a registered copy so that
    // opening the door drops the magnetron in the same cycle.
    always_comb begin
        next_state = state;
        load_lvl   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_evt && door_closed && !timer_done) begin
                    next_state = ST_COOK;
                    load_lvl   = 1'b1;
                end
            end
            ST_COOK: begin
                if (clear_evt) begin
                    next_state = ST_IDLE;
                end else if (!door_closed || stop_evt) begin
                    next_state = ST_PAUSE;
                end else if (timer_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (clear_evt) begin
                    next_state = ST_IDLE;
                end else if (start_evt && door_closed) begin
                    next_state = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear_evt || !door_closed) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase

        cooking = (state == ST_COOK);
        paused  = (state == ST_PAUSE);
        done    = (state == ST_DONE);
        mag     = (state == ST_COOK) && door_closed && (int'(duty_cnt) < on_cyc);
    end

endmodule

// File: tb/tb_mag_power_ctrl.sv
// tb_mag_power_ctrl
//   Self-checking bench for mag_power_ctrl in its default build (no button
//   debounce), PWR_LEVELS=4, DUTY_PERIOD=16. A behavioural model tracks the
//   cooking mode and the total number of cycles spent heating since the
//   last fresh start; the magnetron should be on for the first on-time of
//   every window of that elapsed count.
module tb_mag_power_ctrl;

    localparam int PWR_LEVELS  = 4;
    localparam int DUTY_PERIOD = 16;
    localparam int LVL_W       = 2;

    localparam int M_IDLE  = 0;
    localparam int M_COOK  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             startn = 1'b1;
    logic             stopn = 1'b1;
    logic             clearn = 1'b1;
    logic             door_closed = 1'b0;
    logic             timer_done = 1'b0;
    logic [LVL_W-1:0] power_level = '0;
    logic             mag, cooking, paused, done;

    int checks = 0;
    int passes = 0;
    bit check_en = 1'b0;

    int m_mode = M_IDLE;
    int m_elapsed = 0;
    int m_lvl = 0;
    bit m_hs = 1'b1, m_hp = 1'b1, m_hc = 1'b1;

    mag_power_ctrl #(
        .PWR_LEVELS (PWR_LEVELS),
        .DUTY_PERIOD(DUTY_PERIOD),
        .DEB_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startn     (startn),
        .stopn      (stopn),
        .clearn     (clearn),
        .door_closed(door_closed),
        .timer_done (timer_done),
        .power_level(power_level),
        .mag        (mag),
        .cooking    (cooking),
        .paused     (paused),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the controller as seen from the front panel.
    task automatic model_step();
        bit se, pe, ce;
        if (rst) begin
            m_mode = M_IDLE; m_elapsed = 0; m_lvl = 0;
            m_hs = 1'b1; m_hp = 1'b1; m_hc = 1'b1;
            return;
        end
        se = m_hs && !startn;
        pe = m_hp && !stopn;
        ce = m_hc && !clearn;
        m_hs = startn; m_hp = stopn; m_hc = clearn;
        case (m_mode)
            M_IDLE: if (se && door_closed && !timer_done) begin
                m_mode = M_COOK;
                m_elapsed = 0;
                m_lvl = (int'(power_level) >= PWR_LEVELS) ? PWR_LEVELS - 1 : int'(power_level);
            end
            M_COOK: begin
                m_elapsed++;
                if (ce) m_mode = M_IDLE;
                else if (!door_closed || pe) m_mode = M_PAUSE;
                else if (timer_done) m_mode = M_DONE;
            end
            M_PAUSE: begin
                if (ce) m_mode = M_IDLE;
                else if (se && door_closed) m_mode = M_COOK;
            end
            default: if (ce || !door_closed) m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic model_mag();
        int on;
        on = ((m_lvl + 1) * DUTY_PERIOD) / PWR_LEVELS;
        if (on < 1) on = 1;
        return (m_mode == M_COOK) && door_closed && ((m_elapsed % DUTY_PERIOD) < on);
    endfunction

    always @(posedge clk) begin
        model_step();
        #1;
        if (check_en) begin
            checkOutput("model_cooking", cooking, (m_mode == M_COOK));
            checkOutput("model_paused",  paused,  (m_mode == M_PAUSE));
            checkOutput("model_done",    done,    (m_mode == M_DONE));
            checkOutput("model_mag",     mag,     model_mag());
        end
    end

    // Drive all panel inputs on the falling edge, then let `cycles` rising
    // edges pass and stop just after the last one.
    task automatic applyStimulus(input logic s, input logic p, input logic c,
                                 input logic d, input logic t, input logic [LVL_W-1:0] l,
                                 input int cycles);
        @(negedge clk);
        startn = s; stopn = p; clearn = c;
        door_closed = d; timer_done = t; power_level = l;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;

        // Reset with random panel inputs
        repeat (2) begin
            @(negedge clk);
            startn = 1'($urandom_range(0, 1));
            stopn = 1'($urandom_range(0, 1));
            clearn = 1'($urandom_range(0, 1));
            door_closed = 1'($urandom_range(0, 1));
            timer_done = 1'($urandom_range(0, 1));
            power_level = LVL_W'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        checkOutput("reset_mag", mag, 1'b0);
        checkOutput("reset_cooking", cooking, 1'b0);
        checkOutput("reset_paused", paused, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        check_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 1, 0, 2'd1, 1);

        // Level 1: 8 of 16 cycles on; held start fires once
        applyStimulus(0, 1, 1, 1, 0, 2'd1, 1);
        checkOutput("start_cooking", cooking, 1'b1);
        checkOutput("start_mag", mag, 1'b1);
        cnt = int'(mag);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            cnt += int'(mag);
        end
        checkOutput("duty_window_l1", cnt, 8);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("duty9_off", mag, 1'b0);
        applyStimulus(1, 0, 1, 1, 0, 2'd1, 1);
        checkOutput("stop_paused", paused, 1'b1);
        applyStimulus(1, 1, 1, 1, 0, 2'd1, 3);
        // Resume with a new level requested: window position and level are kept
        applyStimulus(0, 1, 1, 1, 0, 2'd3, 1);
        checkOutput("resume_cooking", cooking, 1'b1);
        checkOutput("resume_held_duty", mag, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("duty_wrap_on", mag, 1'b1);
        applyStimulus(1, 1, 0, 1, 0, 2'd3, 1);
        checkOutput("clear_to_idle", cooking, 1'b0);
        applyStimulus(1, 1, 1, 1, 0, 2'd3, 1);

        // Level 3 and the door safety path
        applyStimulus(0, 1, 1, 1, 0, 2'd3, 1);
        checkOutput("l3_mag", mag, 1'b1);
        applyStimulus(1, 1, 1, 1, 0, 2'd3, 4);
        @(negedge clk);
        door_closed = 1'b0;
        #1;
        checkOutput("door_kills_mag", mag, 1'b0);
        checkOutput("door_still_cook", cooking, 1'b1);
        @(posedge clk); #1;
        checkOutput("door_paused", paused, 1'b1);
        applyStimulus(0, 1, 1, 1, 0, 2'd3, 1);
        checkOutput("door_resume", cooking, 1'b1);
        checkOutput("door_resume_mag", mag, 1'b1);
        applyStimulus(1, 1, 1, 1, 0, 2'd3, 2);

        // Timer expiry, start ignored in DONE, clear returns to IDLE
        applyStimulus(1, 1, 1, 1, 1, 2'd3, 1);
        checkOutput("timer_done", done, 1'b1);
        checkOutput("timer_mag_off", mag, 1'b0);
        applyStimulus(0, 1, 1, 1, 1, 2'd3, 1);
        checkOutput("done_ignores_start", done, 1'b1);
        applyStimulus(1, 1, 1, 1, 1, 2'd3, 1);
        applyStimulus(1, 1, 0, 1, 1, 2'd3, 1);
        checkOutput("done_clear", done, 1'b0);
        applyStimulus(1, 1, 1, 1, 0, 2'd3, 1);

        // Clear beats stop and timer in the same cycle
        applyStimulus(0, 1, 1, 1, 0, 2'd2, 1);
        applyStimulus(1, 1, 1, 1, 0, 2'd2, 2);
        applyStimulus(1, 0, 0, 1, 1, 2'd2, 1);
        checkOutput("clear_wins_cook", cooking, 1'b0);
        checkOutput("clear_wins_pause", paused, 1'b0);
        checkOutput("clear_wins_done", done, 1'b0);
        applyStimulus(1, 1, 1, 1, 0, 2'd2, 1);

        // Start held through door closing produces no new event
        applyStimulus(0, 1, 1, 0, 0, 2'd1, 3);
        applyStimulus(0, 1, 1, 1, 0, 2'd1, 3);
        checkOutput("held_start_no_cook", cooking, 1'b0);
        applyStimulus(1, 1, 1, 1, 0, 2'd1, 1);

        // Reset in the middle of cooking
        applyStimulus(0, 1, 1, 1, 0, 2'd1, 1);
        applyStimulus(1, 1, 1, 1, 0, 2'd1, 3);
        @(negedge clk);
        rst = 1'b1; startn = 1'b0; timer_done = 1'b1;
        @(posedge clk); #1;
        checkOutput("midcook_rst_cook", cooking, 1'b0);
        checkOutput("midcook_rst_mag", mag, 1'b0);
        @(negedge clk);
        rst = 1'b0; startn = 1'b1; timer_done = 1'b0;
        applyStimulus(1, 1, 1, 1, 0, 2'd1, 2);
        checkOutput("post_rst_idle", cooking, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
